// File: rtl/icg_idle_ctrl_if.sv
// -----------------------------------------------------------------------------
// icg_idle_ctrl_if
// Bundles the per-channel request, threshold and status signals of the
// idle-based clock-gating controller.
//   E         : per-channel functional enable / activity request
//   FORCE_ON  : per-channel software override, same effect as E
//   IDLE_TH   : shared idle threshold in cycles (0 = gate immediately)
//   Q         : gated clocks
//   GATED     : registered per-channel "clock stopped" status
//   ALL_GATED : registered AND of all GATED bits
// master drives requests and observes status; slave is the controller.
// -----------------------------------------------------------------------------
interface icg_idle_ctrl_if #(
    parameter int N_CH   = 4,
    parameter int IDLE_W = 8
);
    logic [N_CH-1:0]   E;
    logic [N_CH-1:0]   FORCE_ON;
    logic [IDLE_W-1:0] IDLE_TH;
    logic [N_CH-1:0]   Q;
    logic [N_CH-1:0]   GATED;
    logic              ALL_GATED;

    modport master (
        output E, FORCE_ON, IDLE_TH,
        input  Q, GATED, ALL_GATED
    );

    modport slave (
        input  E, FORCE_ON, IDLE_TH,
        output Q, GATED, ALL_GATED
    );
endinterface

// File: rtl/icg_idle_ctrl.sv
// -----------------------------------------------------------------------------
// icg_idle_ctrl
// Multi-channel clock-gating controller with hysteretic idle gating. Each
// channel's clock stops only after its request has been low for IDLE_TH
// cycles; TE forces every gated clock on for scan without touching the FSMs.
// Ports:
//   CLK : free-running source clock, all state updates on its rising edge
//   RST : synchronous active-high reset (all channels RUN, clocks running)
//   TE  : test enable, combinational into the latch path only
//   bus : icg_idle_ctrl_if slave (E, FORCE_ON, IDLE_TH in; Q, GATED,
//         ALL_GATED out)
// -----------------------------------------------------------------------------
module icg_idle_ctrl #(
    parameter int N_CH   = 4,
    parameter int IDLE_W = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            TE,
    icg_idle_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GATED = 2'd2
    } state_e;

    localparam logic [IDLE_W-1:0] CNT_MAX = '1;

    state_e            state_q [N_CH];
    state_e            state_d [N_CH];
    logic [IDLE_W-1:0] cnt_q   [N_CH];
    logic [IDLE_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]   enr_q, enr_d;
    logic [N_CH-1:0]   gated_q, gated_d;
    logic              all_gated_q;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   iq;

    assign req = bus.E | bus.FORCE_ON;

    // Next-state logic for every channel. The threshold is compared live, so
    // a change of IDLE_TH mid-countdown takes effect at the very next edge.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every output gets a default first so no path leaves it
            // unassigned; otherwise synthesis infers an unintended latch.
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            enr_d[i]   = 1'b1;
            unique case (state_q[i])
                ST_RUN: begin
                    if (req[i]) begin
                        cnt_d[i] = '0;
                    end else if (bus.IDLE_TH == '0) begin
                        state_d[i] = ST_GATED;
                        enr_d[i]   = 1'b0;
                    end else begin
                        // The first low sample already counts as one idle cycle.
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = IDLE_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (req[i]) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= bus.IDLE_TH) begin
                        state_d[i] = ST_GATED;
                        enr_d[i]   = 1'b0;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_GATED: begin
                    if (req[i]) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = '0;
                    end else begin
                        enr_d[i] = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                    cnt_d[i]   = '0;
                end
            endcase
            gated_d[i] = (state_d[i] == ST_GATED);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
            end
            enr_q       <= '1;
            gated_q     <= '0;
            all_gated_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            enr_q       <= enr_d;
            gated_q     <= gated_d;
            all_gated_q <= &gated_d;
        end
    end

    // NOTE: this latch is intentional. It is transparent only while CLK is
    // low and holds through the high phase, so an ENR or TE change can never
    // start or cut a pulse on Q mid-phase.
    always_latch begin
        if (!CLK) begin
            iq = enr_q | {N_CH{TE}};
        end
    end

    assign bus.Q         = {N_CH{CLK}} & iq;
    assign bus.GATED     = gated_q;
    assign bus.ALL_GATED = all_gated_q;

endmodule

// File: tb/tb_icg_idle_ctrl.sv
module tb_icg_idle_ctrl;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HALF = 5;

    logic CLK = 1'b0;
    logic RST;
    logic TE;

    int total = 0;
    int bad   = 0;

    icg_idle_ctrl_if #(.N_CH(N), .IDLE_W(W)) bus ();

    icg_idle_ctrl #(.N_CH(N), .IDLE_W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .TE  (TE),
        .bus (bus)
    );

    always #HALF CLK = ~CLK;

    // Pulse counter and glitch monitor: every high pulse on Q must be exactly
    // one half period wide.
    logic [N-1:0] q_prev = '0;
    time          rise_t [N];
    int           pulses [N];
    int           glitches = 0;
    int           snap   [N];

    always @(bus.Q) begin
        for (int i = 0; i < N; i++) begin
            if (bus.Q[i] === 1'b1 && q_prev[i] !== 1'b1) begin
                rise_t[i] = $time;
                pulses[i] = pulses[i] + 1;
            end else if (bus.Q[i] !== 1'b1 && q_prev[i] === 1'b1) begin
                if ($time - rise_t[i] != HALF) glitches = glitches + 1;
            end
        end
        q_prev = bus.Q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap_all();
        for (int i = 0; i < N; i++) snap[i] = pulses[i];
    endtask

    task automatic chk_pulses(input string tag, input int ch, input int exp);
        check(tag, pulses[ch] - snap[ch], exp);
    endtask

    initial begin
        RST          = 1'b1;
        TE           = 1'b0;
        bus.E        = '0;
        bus.FORCE_ON = '0;
        bus.IDLE_TH  = 8'd3;

        // Reset: clocks run, status low.
        step();
        snap_all();
        step();
        for (int i = 0; i < N; i++) chk_pulses($sformatf("rst_pulse%0d", i), i, 1);
        check("rst_gated", bus.GATED, 4'h0);
        check("rst_all", bus.ALL_GATED, 1'b0);

        // Release with IDLE_TH=3: edges k..k+3 pulse, then stop.
        RST = 1'b0;
        snap_all();
        step(); step(); step();
        check("th3_not_yet", bus.GATED, 4'h0);
        step();
        check("th3_gated", bus.GATED, 4'hF);
        check("th3_all", bus.ALL_GATED, 1'b1);
        step(); step();
        for (int i = 0; i < N; i++) chk_pulses($sformatf("th3_pulses%0d", i), i, 4);

        // IDLE_TH=0 on channel 0: gate on first low sample, wake one edge late.
        bus.IDLE_TH = 8'd0;
        bus.E       = 4'b0001;
        snap_all();
        step();
        check("th0_wake_gated", bus.GATED, 4'b1110);
        check("th0_wake_all", bus.ALL_GATED, 1'b0);
        step();
        bus.E = 4'b0000;
        step();
        check("th0_gated", bus.GATED, 4'hF);
        check("th0_all", bus.ALL_GATED, 1'b1);
        step();
        chk_pulses("th0_pulses", 0, 2);
        bus.E = 4'b0001;
        snap_all();
        step();
        check("th0_rewake_gated", bus.GATED, 4'b1110);
        step();
        chk_pulses("th0_rewake_pulses", 0, 1);
        bus.E = 4'b0000;
        step();
        check("th0_regate", bus.GATED, 4'hF);

        // IDLE_TH=5 on channel 1: a one-cycle request restarts the countdown.
        bus.IDLE_TH = 8'd5;
        bus.E       = 4'b0010;
        step();
        bus.E = 4'b0000;
        repeat (4) step();
        check("th5_low4", bus.GATED[1], 1'b0);
        bus.E = 4'b0010;
        step();
        check("th5_blip", bus.GATED[1], 1'b0);
        bus.E = 4'b0000;
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("th5_cnt%0d", j), bus.GATED[1], (j == 6));
        end

        // FORCE_ON on channel 2 keeps its clock alive.
        bus.IDLE_TH  = 8'd1;
        bus.FORCE_ON = 4'b0100;
        step();
        snap_all();
        repeat (4) step();
        chk_pulses("force_pulses", 2, 4);
        check("force_gated", bus.GATED[2], 1'b0);
        bus.FORCE_ON = 4'b0000;
        step();
        check("force_idle", bus.GATED[2], 1'b0);
        step();
        check("force_drop", bus.GATED, 4'hF);
        check("force_all", bus.ALL_GATED, 1'b1);

        // TE asserted mid high phase: clocks resume from next edge, FSMs untouched.
        #1;
        TE = 1'b1;
        snap_all();
        step(); step(); step();
        chk_pulses("te_on_ch0", 0, 3);
        chk_pulses("te_on_ch3", 3, 3);
        check("te_on_gated", bus.GATED, 4'hF);
        check("te_on_all", bus.ALL_GATED, 1'b1);
        #1;
        TE = 1'b0;
        snap_all();
        step(); step(); step();
        chk_pulses("te_off_ch0", 0, 0);
        chk_pulses("te_off_ch3", 3, 0);
        check("te_glitch", glitches, 0);

        // Lowering IDLE_TH below a running count gates at the next edge.
        bus.IDLE_TH = 8'd200;
        bus.E       = 4'b1000;
        step();
        bus.E = 4'b0000;
        repeat (50) step();
        check("th200_cnt50", bus.GATED[3], 1'b0);
        bus.IDLE_TH = 8'd10;
        step();
        check("th_lowered", bus.GATED[3], 1'b1);

        // Reset from GATED: RUN immediately, clocks back the next edge.
        RST = 1'b1;
        step();
        check("rst2_gated", bus.GATED, 4'h0);
        check("rst2_all", bus.ALL_GATED, 1'b0);
        RST = 1'b0;
        snap_all();
        step();
        chk_pulses("rst2_pulse3", 3, 1);
        chk_pulses("rst2_pulse0", 0, 1);
        check("final_glitch", glitches, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
